hdc_csr_fifo: RTL and testbench
===============================

Name: hdc_csr_fifo

Overview:
Parametrised CSR manager for the programmable SBD-HDC accelerator. It replaces single-entry input/status handshaking with an input FIFO (CPU pushes samples ahead of the datapath) and an output FIFO (results queued for the CPU). It adds a registered valid-ready response, sticky overflow flags, a read-to-pop output register and an interrupt line. It sits between the core's CSR port and the accelerator datapath.

Parameters:
CSR_WIDTH, 32, data width of CSR bus and registers
CSR_ADDR_WIDTH, 32, CSR address width
IN_DEPTH, 4, input FIFO entries (power of 2, ≥2)
OUT_DEPTH, 4, output FIFO entries (power of 2, ≥2)
OUT_WIDTH, 5, accelerator result width (≤30)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
csr_addr_i  in  CSR_ADDR_WIDTH  register address
csr_wr_data_i  in  CSR_WIDTH  write data
csr_wr_en_i  in  1  1=write, 0=read
csr_req_valid_i / csr_req_ready_o  in/out  1  request handshake
csr_rd_data_o  out  CSR_WIDTH  registered read data
csr_rsp_valid_o / csr_rsp_ready_i  out/in  1  response handshake
start_o  out  1  one-cycle start pulse
soft_rst_no  out  1  one-cycle active-low datapath reset pulse
in_valid_o / in_ready_i  out/in  1  input FIFO head handshake to datapath
in_value_o, in_shift_o  out  6 each  head sample value, shift amount
in_done_o  out  1  head marks last sample
running_i  in  1  datapath busy
out_valid_i  in  1  result strobe, no backpressure
out_value_i  in  OUT_WIDTH  result
bind_cfg_o  out  3  {shift_binding, signature_enc, sliding_window}
bund_cfg_o  out  24  bundling fields, same bit layout as the current CSR_P_BUNDLING
am_addr_base_o, am_addr_max_o  out  CSR_WIDTH each  AM bounds
irq_o  out  1  interrupt

Behaviour:
- Register map:
  - 0 START: W b0=1 → start_o pulse in the accept cycle+1. Reads 0.
  - 1 INPUT: W pushes {b12 done, b11:6 shift, b5:0 value}. R returns input count.
  - 2 STATUS (RO): b0 running_i; b1 input FIFO not full; b2 output FIFO not empty; b3 in_ovf; b4 out_ovf; b15:8 in count; b23:16 out count.
  - 3 P_BINDING: RW, b2:0.
  - 4 P_BUNDLING: RW, b23:0.
  - 5 AM_BASE, 6 AM_MAX: RW, full width.
  - 7 RESET: W b0=1 → soft_rst_no low for exactly one cycle after accept. Reads 0.
  - 8 OUTPUT: R returns {b31 valid, OUT_WIDTH-1:0 head} and pops if non-empty. Empty → all 0, no pop. Writes ignored.
  - 9 IRQ: b0 irq_en RW; W b1=1 clears in_ovf, W b2=1 clears out_ovf.
  - Other addresses: writes ignored, reads 0.
- Handshake:
  - csr_req_ready_o = !csr_rsp_valid_o || csr_rsp_ready_i (one outstanding request).
  - Accept = req_valid && req_ready.
  - Side effects (write, push, pop, pulses) occur only on accept, exactly once.
  - rsp_valid rises the cycle after accept; rd_data is captured at accept and held stable until rsp_ready.
  - Writes also respond, with rd_data = 0.
  - Back-to-back accepts are allowed when rsp_ready stays 1 (throughput 1/cycle).
- Input FIFO:
  - Push on accepted INPUT write; pop when in_valid_o && in_ready_i.
  - Push when full: entry dropped, in_ovf set.
  - Push and pop in the same cycle while full: the pop frees a slot and the push succeeds.
  - in_valid_o = not empty; head outputs are 0 when empty.
- Output FIFO:
  - Push on out_valid_i; pop on accepted OUTPUT read.
  - Push when full (and no same-cycle pop): result dropped, out_ovf set.
  - Simultaneous push/pop on a non-full FIFO: count unchanged; the pop returns the old head.
- Overflow flags: sticky, set has priority over a same-cycle clear.
- irq_o = irq_en && (out FIFO not empty || out_ovf), registered (one cycle after the condition).
- Soft reset (START/RESET path): during the soft_rst_no low cycle, both FIFOs flush and both ovf flags clear. Config registers and irq_en are kept.
- rst_ni low (synchronous), all state cleared:
  - registers 0, FIFOs empty, flags 0;
  - start_o=0, soft_rst_no=1, rsp_valid=0, rd_data=0, irq_o=0, in_valid_o=0.
  - Any pending response is discarded.
- Count fields are zero-extended; depth ≤ 255.

Test Plan:
1. Reset, read STATUS → rsp next cycle, data 0x0000_0002 (not full, all else 0); irq_o=0, soft_rst_no=1.
2. in_ready_i=0, write INPUT 0x1A3, 0x005, 0x1005, 0x7FF, 0x001 (IN_DEPTH=4) → STATUS in count=4, b1=0, b3=1. Raise in_ready_i → heads appear in order (value 0x23/shift 6, 5/0, 5/0 done=1, 0x3F/0x1F); 5th entry absent.
3. Pulse out_valid_i with 3,17,30; read OUTPUT ×4 → 0x8000_0003, 0x8000_0011, 0x8000_001E, 0x0000_0000.
4. Set irq_en, push one result → irq_o=1 one cycle later. Pop → irq_o=0. Overflow output (5 pushes) → irq stays 1 until W IRQ 0x5 and FIFO drained.
5. Hold csr_rsp_ready_i=0 for 3 cycles after a read of AM_BASE (0xDEAD_BEEF) → req_ready=0, rd_data stable. Second request waits and its side effect is not duplicated.
6. Config P_BUNDLING=0xABCDEF, fill both FIFOs, write RESET 1 → soft_rst_no low one cycle, counts 0, flags 0, P_BUNDLING still 0xABCDEF. Write START 1 → start_o single pulse.

Source files
------------

// File: rtl/hdc_csr_fifo_if.sv
// hdc_csr_fifo_if: valid/ready CSR request/response bus between the core and the CSR manager
interface hdc_csr_fifo_if #(
  parameter int CSR_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 32
);
  logic [CSR_ADDR_WIDTH-1:0] addr;
  logic [CSR_WIDTH-1:0] wr_data;
  logic wr_en;
  logic req_valid;
  logic req_ready;
  logic [CSR_WIDTH-1:0] rd_data;
  logic rsp_valid;
  logic rsp_ready;
  modport master (
    output addr, wr_data, wr_en, req_valid, rsp_ready,
    input req_ready, rd_data, rsp_valid
  );
  modport slave (
    input addr, wr_data, wr_en, req_valid, rsp_ready,
    output req_ready, rd_data, rsp_valid
  );
endinterface

// File: rtl/hdc_csr_fifo.sv
// hdc_csr_fifo: CSR manager with input/output FIFOs, sticky overflow flags and irq for the SBD-HDC accelerator
module hdc_csr_fifo #(
  parameter int CSR_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 32,
  parameter int IN_DEPTH = 4,
  parameter int OUT_DEPTH = 4,
  parameter int OUT_WIDTH = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  hdc_csr_fifo_if.slave        csr,
  output logic                 start_o,
  output logic                 soft_rst_no,
  output logic                 in_valid_o,
  input  logic                 in_ready_i,
  output logic [5:0]           in_value_o,
  output logic [5:0]           in_shift_o,
  output logic                 in_done_o,
  input  logic                 running_i,
  input  logic                 out_valid_i,
  input  logic [OUT_WIDTH-1:0] out_value_i,
  output logic [2:0]           bind_cfg_o,
  output logic [23:0]          bund_cfg_o,
  output logic [CSR_WIDTH-1:0] am_addr_base_o,
  output logic [CSR_WIDTH-1:0] am_addr_max_o,
  output logic                 irq_o
);
  localparam int IW = $clog2(IN_DEPTH);
  localparam int OW = $clog2(OUT_DEPTH);
  logic [12:0] in_mem_q [IN_DEPTH];
  logic [OUT_WIDTH-1:0] out_mem_q [OUT_DEPTH];
  logic [IW-1:0] in_rd_q, in_wr_q;
  logic [OW-1:0] out_rd_q, out_wr_q;
  logic [IW:0] in_cnt_q, in_cnt_d;
  logic [OW:0] out_cnt_q, out_cnt_d;
  logic in_ovf_q, in_ovf_d, out_ovf_q, out_ovf_d;
  logic rsp_valid_q, start_q, srst_q, irq_q, irq_en_q;
  logic [CSR_WIDTH-1:0] rd_data_q, rdata, am_base_q, am_max_q;
  logic [2:0] bind_q;
  logic [23:0] bund_q;
  logic [12:0] in_head;
  logic [OUT_WIDTH-1:0] out_head;
  logic [3:0] idx;
  logic in_map, accept, wr_acc, rd_acc;
  logic in_push, in_pop, in_full, in_push_ok;
  logic out_pop, out_full, out_empty, out_push_ok;
  assign csr.req_ready = !rsp_valid_q || csr.rsp_ready;
  assign csr.rsp_valid = rsp_valid_q;
  assign csr.rd_data = rd_data_q;
  assign idx = csr.addr[3:0];
  assign in_map = csr.addr[CSR_ADDR_WIDTH-1:4] == '0;
  assign accept = csr.req_valid && csr.req_ready;
  assign wr_acc = accept && csr.wr_en && in_map;
  assign rd_acc = accept && !csr.wr_en && in_map;
  assign in_valid_o = in_cnt_q != '0;
  assign in_full = in_cnt_q == (IW+1)'(IN_DEPTH);
  assign in_push = wr_acc && idx == 4'd1;
  assign in_pop = in_valid_o && in_ready_i;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign in_push_ok = in_push && (!in_full || in_pop);
  assign in_head = in_valid_o ? in_mem_q[in_rd_q] : '0;
  assign {in_done_o, in_shift_o, in_value_o} = in_head;
  assign out_empty = out_cnt_q == '0;
  assign out_full = out_cnt_q == (OW+1)'(OUT_DEPTH);
  assign out_pop = rd_acc && idx == 4'd8 && !out_empty;
  assign out_push_ok = out_valid_i && (!out_full || out_pop);
  assign out_head = out_empty ? '0 : out_mem_q[out_rd_q];
  assign in_cnt_d = srst_q ? '0 : in_cnt_q + (IW+1)'(in_push_ok) - (IW+1)'(in_pop);
  assign out_cnt_d = srst_q ? '0 : out_cnt_q + (OW+1)'(out_push_ok) - (OW+1)'(out_pop);
  // set beats a same-cycle clear; soft reset beats both
  assign in_ovf_d = !srst_q && ((in_push && !in_push_ok) ||
                    (in_ovf_q && !(wr_acc && idx == 4'd9 && csr.wr_data[1])));
  assign out_ovf_d = !srst_q && ((out_valid_i && !out_push_ok) ||
                     (out_ovf_q && !(wr_acc && idx == 4'd9 && csr.wr_data[2])));
  assign start_o = start_q;
  assign soft_rst_no = !srst_q;
  assign irq_o = irq_q;
  assign bind_cfg_o = bind_q;
  assign bund_cfg_o = bund_q;
  assign am_addr_base_o = am_base_q;
  assign am_addr_max_o = am_max_q;
  always_comb begin
    rdata = '0;
    if (in_map)
      case (idx)
        4'd1: rdata = CSR_WIDTH'(in_cnt_q);
        4'd2: rdata[23:0] = {8'(out_cnt_q), 8'(in_cnt_q), 3'b0, out_ovf_q, in_ovf_q,
                             !out_empty, !in_full, running_i};
        4'd3: rdata[2:0] = bind_q;
        4'd4: rdata[23:0] = bund_q;
        4'd5: rdata = am_base_q;
        4'd6: rdata = am_max_q;
        4'd8: begin
          rdata[CSR_WIDTH-1] = !out_empty;
          rdata[OUT_WIDTH-1:0] = out_head;
        end
        4'd9: rdata[0] = irq_en_q;
        default: rdata = '0;
      endcase
  end
  always_ff @(posedge clk_i) begin
    if (in_push_ok) in_mem_q[in_wr_q] <= csr.wr_data[12:0];
    if (out_push_ok) out_mem_q[out_wr_q] <= out_value_i;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rd_data_q <= '0;
      start_q <= 1'b0;
      srst_q <= 1'b0;
      irq_q <= 1'b0;
      irq_en_q <= 1'b0;
      bind_q <= '0;
      bund_q <= '0;
      am_base_q <= '0;
      am_max_q <= '0;
      in_cnt_q <= '0;
      in_rd_q <= '0;
      in_wr_q <= '0;
      out_cnt_q <= '0;
      out_rd_q <= '0;
      out_wr_q <= '0;
      in_ovf_q <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      rsp_valid_q <= accept || (rsp_valid_q && !csr.rsp_ready);
      if (accept) rd_data_q <= csr.wr_en ? '0 : rdata;
      start_q <= wr_acc && idx == 4'd0 && csr.wr_data[0];
      srst_q <= wr_acc && idx == 4'd7 && csr.wr_data[0];
      irq_q <= irq_en_q && (!out_empty || out_ovf_q);
      if (wr_acc && idx == 4'd3) bind_q <= csr.wr_data[2:0];
      if (wr_acc && idx == 4'd4) bund_q <= csr.wr_data[23:0];
      if (wr_acc && idx == 4'd5) am_base_q <= csr.wr_data;
      if (wr_acc && idx == 4'd6) am_max_q <= csr.wr_data;
      if (wr_acc && idx == 4'd9) irq_en_q <= csr.wr_data[0];
      in_cnt_q <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      in_ovf_q <= in_ovf_d;
      out_ovf_q <= out_ovf_d;
      in_rd_q <= srst_q ? '0 : in_rd_q + IW'(in_pop);
      in_wr_q <= srst_q ? '0 : in_wr_q + IW'(in_push_ok);
      out_rd_q <= srst_q ? '0 : out_rd_q + OW'(out_pop);
      out_wr_q <= srst_q ? '0 : out_wr_q + OW'(out_push_ok);
    end
  end
endmodule

// File: tb/tb_hdc_csr_fifo.sv
// tb_hdc_csr_fifo: directed plan plus random traffic checked against a queue-based model
module tb_hdc_csr_fifo;
  localparam int W = 32, D = 4, OW = 5;
  logic clk = 1'b0, rst_n;
  always #5 clk = ~clk;
  hdc_csr_fifo_if bus();
  logic start, srst_n, in_valid, in_ready, in_done, running, out_valid, irq;
  logic [5:0] in_value, in_shift;
  logic [OW-1:0] out_value;
  logic [2:0] bind_cfg;
  logic [23:0] bund_cfg;
  logic [W-1:0] am_base, am_max;
  hdc_csr_fifo dut (
    .clk_i(clk), .rst_ni(rst_n), .csr(bus),
    .start_o(start), .soft_rst_no(srst_n),
    .in_valid_o(in_valid), .in_ready_i(in_ready),
    .in_value_o(in_value), .in_shift_o(in_shift), .in_done_o(in_done),
    .running_i(running), .out_valid_i(out_valid), .out_value_i(out_value),
    .bind_cfg_o(bind_cfg), .bund_cfg_o(bund_cfg),
    .am_addr_base_o(am_base), .am_addr_max_o(am_max), .irq_o(irq)
  );
  int checks = 0, errors = 0;
  logic [12:0] m_in[$];
  logic [OW-1:0] m_out[$];
  bit m_in_ovf, m_out_ovf, m_irq_en, m_irq, m_start, m_srst, m_rsp_v, last_acc;
  logic [31:0] m_rd, m_bind, m_bund, m_base, m_max, r;
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] read_val(logic [31:0] a);
    case (a)
      1: return m_in.size();
      2: return (m_out.size() << 16) | (m_in.size() << 8) | (32'(m_out_ovf) << 4) |
                (32'(m_in_ovf) << 3) | (32'(m_out.size() != 0) << 2) |
                (32'(m_in.size() < D) << 1) | 32'(running);
      3: return m_bind;
      4: return m_bund;
      5: return m_base;
      6: return m_max;
      8: return m_out.size() != 0 ? (32'h8000_0000 | 32'(m_out[0])) : 0;
      9: return 32'(m_irq_en);
      default: return 0;
    endcase
  endfunction
  task automatic idle();
    bus.req_valid = 0; bus.wr_en = 0; bus.addr = 0; bus.wr_data = 0; bus.rsp_ready = 1;
    in_ready = 0; out_valid = 0; out_value = 0; running = 0;
  endtask
  task automatic compare_all();
    logic [12:0] h;
    h = m_in.size() != 0 ? m_in[0] : 13'h0;
    check("rsp_valid", bus.rsp_valid, m_rsp_v);
    check("rd_data", bus.rd_data, m_rd);
    check("start", start, m_start);
    check("soft_rst_n", srst_n, !m_srst);
    check("irq", irq, m_irq);
    check("in_valid", in_valid, m_in.size() != 0);
    check("in_head", {in_done, in_shift, in_value}, h);
    check("bind", bind_cfg, m_bind[2:0]);
    check("bund", bund_cfg, m_bund[23:0]);
    check("am_base", am_base, m_base);
    check("am_max", am_max, m_max);
  endtask
  task automatic step();
    bit acc, wr, set_in, set_out;
    logic [31:0] a, dat, rv;
    bit irq_n;
    #1;
    wr = bus.wr_en; a = bus.addr; dat = bus.wr_data;
    acc = bus.req_valid && (!m_rsp_v || bus.rsp_ready);
    check("req_ready", bus.req_ready, !m_rsp_v || bus.rsp_ready);
    rv = wr ? 0 : read_val(a);
    irq_n = m_irq_en && (m_out.size() != 0 || m_out_ovf);
    set_in = 0; set_out = 0;
    if (in_ready && m_in.size() != 0) void'(m_in.pop_front());
    if (acc && wr && a == 1) begin
      if (m_in.size() < D) m_in.push_back(dat[12:0]); else set_in = 1;
    end
    if (acc && !wr && a == 8 && m_out.size() != 0) void'(m_out.pop_front());
    if (out_valid) begin
      if (m_out.size() < D) m_out.push_back(out_value); else set_out = 1;
    end
    m_in_ovf = set_in || (m_in_ovf && !(acc && wr && a == 9 && dat[1]));
    m_out_ovf = set_out || (m_out_ovf && !(acc && wr && a == 9 && dat[2]));
    if (m_srst) begin
      m_in.delete(); m_out.delete(); m_in_ovf = 0; m_out_ovf = 0;
    end
    if (acc && wr) begin
      if (a == 3) m_bind = dat & 32'h7;
      if (a == 4) m_bund = dat & 32'hFF_FFFF;
      if (a == 5) m_base = dat;
      if (a == 6) m_max = dat;
      if (a == 9) m_irq_en = dat[0];
    end
    m_start = acc && wr && a == 0 && dat[0];
    m_srst = acc && wr && a == 7 && dat[0];
    if (acc) m_rd = rv;
    m_rsp_v = acc || (m_rsp_v && !bus.rsp_ready);
    m_irq = irq_n;
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask
  task automatic xact(input logic [31:0] a, input bit wr, input logic [31:0] dat, output logic [31:0] rd);
    bit done = 0;
    bus.addr = a; bus.wr_en = wr; bus.wr_data = dat; bus.req_valid = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = last_acc;
    end
    if (!done) check("xact_timeout", 0, 1);
    bus.req_valid = 0;
    rd = bus.rd_data;
  endtask
  task automatic push_out(input logic [OW-1:0] v);
    out_valid = 1; out_value = v;
    step();
    out_valid = 0;
  endtask
  initial begin
    logic [12:0] heads [4];
    heads = '{13'h0_1A3, 13'h0005, 13'h1005, 13'h07FF};
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    m_in.delete(); m_out.delete();
    {m_in_ovf, m_out_ovf, m_irq_en, m_irq, m_start, m_srst, m_rsp_v} = '0;
    {m_rd, m_bind, m_bund, m_base, m_max} = '0;
    compare_all();
    xact(2, 0, 0, r);
    check("status_rst", r, 32'h2);
    check("irq_rst", irq, 0);
    check("srst_n_rst", srst_n, 1);
    foreach (heads[i]) xact(1, 1, 32'(heads[i]), r);
    xact(1, 1, 32'h001, r);
    xact(2, 0, 0, r);
    check("status_full", r & 32'hFF0A, 32'h0408);
    for (int i = 0; i < 4; i++) begin
      check("fifo_head", {in_done, in_shift, in_value}, heads[i]);
      in_ready = 1;
      step();
      in_ready = 0;
    end
    check("in_drained", in_valid, 0);
    push_out(3); push_out(17); push_out(30);
    xact(8, 0, 0, r); check("out0", r, 32'h8000_0003);
    xact(8, 0, 0, r); check("out1", r, 32'h8000_0011);
    xact(8, 0, 0, r); check("out2", r, 32'h8000_001E);
    xact(8, 0, 0, r); check("out_empty", r, 32'h0);
    xact(9, 1, 1, r);
    push_out(7);
    step();
    check("irq_set", irq, 1);
    xact(8, 0, 0, r); check("out_pop7", r, 32'h8000_0007);
    step();
    check("irq_clr", irq, 0);
    for (int i = 1; i <= 5; i++) push_out(5'(i));
    step();
    check("irq_ovf", irq, 1);
    xact(9, 1, 5, r);
    step();
    check("irq_hold", irq, 1);
    for (int i = 1; i <= 4; i++) begin
      xact(8, 0, 0, r);
      check("ovf_drain", r, 32'h8000_0000 | 32'(i));
    end
    step(); step();
    check("irq_drained", irq, 0);
    xact(5, 1, 32'hDEAD_BEEF, r);
    step();
    bus.rsp_ready = 0;
    xact(5, 0, 0, r);
    check("am_base_rd", r, 32'hDEAD_BEEF);
    bus.addr = 1; bus.wr_en = 1; bus.wr_data = 32'h2A; bus.req_valid = 1;
    repeat (3) begin
      step();
      check("req_blocked", bus.req_ready, 0);
      check("rd_stable", bus.rd_data, 32'hDEAD_BEEF);
    end
    bus.rsp_ready = 1;
    step();
    bus.req_valid = 0;
    xact(1, 0, 0, r);
    check("no_dup_push", r, 1);
    xact(4, 1, 32'hABCDEF, r);
    repeat (4) xact(1, 1, 32'(m_in.size()), r);
    for (int i = 0; i < 4; i++) push_out(5'(i + 9));
    xact(7, 1, 1, r);
    check("srst_low", srst_n, 0);
    step();
    check("srst_high", srst_n, 1);
    xact(2, 0, 0, r);
    check("status_flushed", r, 32'h2);
    xact(4, 0, 0, r);
    check("bund_kept", r, 32'hABCDEF);
    xact(0, 1, 1, r);
    check("start_pulse", start, 1);
    step();
    check("start_end", start, 0);
    for (int i = 0; i < 3000; i++) begin
      bus.req_valid = $urandom_range(0, 1);
      bus.wr_en = $urandom_range(0, 1);
      bus.addr = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 11);
      bus.wr_data = $urandom;
      bus.rsp_ready = $urandom_range(0, 4) != 0;
      in_ready = $urandom_range(0, 2) == 0;
      out_valid = $urandom_range(0, 2) == 0;
      out_value = OW'($urandom);
      running = $urandom_range(0, 1);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
